seq_multiplier_4: RTL and testbench

- Sequential 4x4 unsigned shift-add multiplier that sits directly downstream of the 4-bit ripple adder (`full_adder_4`).
- Each cycle it feeds a partial-product high nibble and the multiplicand into one `full_adder_4` instance.
- It consumes that adder's sum and carry_out, then shifts the result into an 8-bit product register.
- Provides the processor's MUL path with a start/busy/done handshake.

---
 rtl/seq_multiplier_4.sv | 137 +++++++++++++
 tb/tb_seq_multiplier_4.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier_4.sv
// Sequential 4x4 unsigned shift-add multiplier built around one 4-bit ripple adder.
// One add-and-shift per clock; start/busy/done handshake; registered outputs only.

// 4-bit ripple-carry adder used as the multiplier datapath.
module full_adder_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carry_in,
  output logic [3:0] sum,
  output logic       carry_out
);

  logic [4:0] carry;

  assign carry[0] = carry_in;

  // One full-adder cell per bit, carry rippling upward.
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign carry_out = carry[4];

endmodule

module seq_multiplier_4 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = 2;

  // The datapath is a single 4-bit adder; any other width cannot be built.
  if (WIDTH != 4) begin : g_width_check
    $error("seq_multiplier_4: WIDTH must be 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_reg, a_nxt;
  logic [WIDTH-1:0]   p_hi, p_hi_nxt;
  logic [WIDTH-1:0]   q_reg, q_nxt;
  logic [CW-1:0]      count, count_nxt;
  logic [PW-1:0]      product_nxt;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_sum;
  logic               add_co;
  logic [PW-1:0]      shifted;

  // Multiplicand is gated by the current multiplier LSB; the adder is always in the path.
  assign add_b = q_reg[0] ? a_reg : WIDTH'(0);

  full_adder_4 u_adder (
    .a         (p_hi),
    .b         (add_b),
    .carry_in  (1'b0),
    .sum       (add_sum),
    .carry_out (add_co)
  );

  // 9-bit right shift of {carry, sum, Q} dropping the consumed multiplier bit.
  assign shifted = {add_co, add_sum, q_reg[WIDTH-1:1]};

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_reg   <= '0;
      p_hi    <= '0;
      q_reg   <= '0;
      count   <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      a_reg   <= a_nxt;
      p_hi    <= p_hi_nxt;
      q_reg   <= q_nxt;
      count   <= count_nxt;
      product <= product_nxt;
      busy    <= (state_nxt == CALC);
      done    <= (state_nxt == DONE);
    end
  end

  // Next-state and datapath update; operands are loaded only on an accepted start.
  always_comb begin
    state_nxt   = state;
    a_nxt       = a_reg;
    p_hi_nxt    = p_hi;
    q_nxt       = q_reg;
    count_nxt   = count;
    product_nxt = product;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = CALC;
          a_nxt     = multiplicand;
          q_nxt     = multiplier;
          p_hi_nxt  = '0;
          count_nxt = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      CALC: begin
        p_hi_nxt  = shifted[PW-1:WIDTH];
        q_nxt     = shifted[WIDTH-1:0];
        count_nxt = count + CW'(1);
        if (count == CW'(3)) begin
          state_nxt   = DONE;
          product_nxt = shifted;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_multiplier_4.sv
// Scoreboard bench for seq_multiplier_4: expected products queued at start, checked on done.
module tb_seq_multiplier_4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] multiplicand;
  logic [3:0] multiplier;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_prod = 8'h00;

  seq_multiplier_4 #(.WIDTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor: product compared on done, otherwise it must hold its last value.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_prod = 8'h00;
    end else begin
      check("busy_done_exclusive", {7'b0, busy & done}, 8'h00);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", {7'b0, done}, 8'h00);
        end else begin
          last_prod = exp_q.pop_front();
          check("product", product, last_prod);
        end
      end else begin
        check("product_hold", product, last_prod);
      end
    end
  end

  // Drive a start at the current negedge and queue its expected product.
  task automatic drive_start(input logic [3:0] a, input logic [3:0] b);
    start        = 1'b1;
    multiplicand = a;
    multiplier   = b;
    exp_q.push_back({4'b0, a} * {4'b0, b});
  endtask

  // From the negedge right after the accept edge, count edges until done is seen.
  task automatic wait_done(output int edges, output int busy_cycles);
    edges = 0;
    busy_cycles = 0;
    while (!done && edges < 20) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b);
    int e, bc;
    @(negedge clk);
    drive_start(a, b);
    @(negedge clk);
    start        = 1'b0;
    multiplicand = 4'($urandom_range(0, 15));
    multiplier   = 4'($urandom_range(0, 15));
    wait_done(e, bc);
    check({tag, "_latency"}, 8'(e), 8'd4);
    check({tag, "_busy_cycles"}, 8'(bc), 8'd4);
    @(negedge clk);
    check({tag, "_done_pulse"}, {7'b0, done}, 8'h00);
    check({tag, "_idle_busy"}, {7'b0, busy}, 8'h00);
  endtask

  initial begin
    int e, bc;
    rst_n        = 1'b0;
    start        = 1'b0;
    multiplicand = 4'h0;
    multiplier   = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_busy", {7'b0, busy}, 8'h00);
    check("rst_done", {7'b0, done}, 8'h00);
    check("rst_product", product, 8'h00);
    #2 rst_n = 1'b1;

    run_op("a3b5", 4'd3, 4'd5);
    run_op("a15b15", 4'd15, 4'd15);
    run_op("a15b1", 4'd15, 4'd1);
    run_op("a1b15", 4'd1, 4'd15);
    run_op("a9b0", 4'd9, 4'd0);
    run_op("a0b9", 4'd0, 4'd9);

    // Back-to-back: new start held during the DONE cycle.
    @(negedge clk);
    drive_start(4'd2, 4'd7);
    @(negedge clk);
    start = 1'b0;
    wait_done(e, bc);
    check("b2b_first_latency", 8'(e), 8'd4);
    drive_start(4'd6, 4'd6);
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_idle_busy", {7'b0, busy}, 8'h01);
    check("b2b_done_drop", {7'b0, done}, 8'h00);
    wait_done(e, bc);
    check("b2b_second_latency", 8'(e), 8'd5 - 8'd1);
    @(negedge clk);

    // start and operand changes during CALC must be ignored.
    @(negedge clk);
    drive_start(4'd5, 4'd3);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start        = 1'b1;
    multiplicand = 4'd9;
    multiplier   = 4'd9;
    @(negedge clk);
    start        = 1'b0;
    multiplicand = 4'd12;
    multiplier   = 4'd14;
    wait_done(e, bc);
    check("calc_ignore_latency", 8'(e), 8'd2);
    repeat (8) @(negedge clk);

    // Asynchronous reset in the middle of iteration 2 abandons the operation.
    start        = 1'b1;
    multiplicand = 4'd7;
    multiplier   = 4'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {7'b0, busy}, 8'h00);
    check("midrst_done", {7'b0, done}, 8'h00);
    check("midrst_product", product, 8'h00);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_no_done", {7'b0, done}, 8'h00);
    run_op("a4b4", 4'd4, 4'd4);

    repeat (3) @(negedge clk);
    check("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
